// File: rtl/mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// Module : mem_lsu_pkg
// Brief  : Shared constants and decode helpers for the MEM-stage LSU.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
package mem_lsu_pkg;

  // Reset level seen on the rst pin (active low).
  localparam logic RST_ENABLE = 1'b0;

  // Major opcodes handled by the LSU.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Access size in bytes for a load; unknown encodings act as words.
  function automatic logic [2:0] ld_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return 3'd1;
      F3_LH, F3_LHU: return 3'd2;
      F3_LW:         return 3'd4;
      default:       return 3'd4;
    endcase
  endfunction

  // Access size in bytes for a store; unknown encodings act as words.
  function automatic logic [2:0] st_size(input logic [2:0] f3);
    case (f3)
      F3_SB:   return 3'd1;
      F3_SH:   return 3'd2;
      F3_SW:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  // Signed sub-word loads need sign extension.
  function automatic logic ld_signed(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// Module : mem_lsu_if
// Brief  : Per-beat request/grant bus between the LSU and memory controller.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
interface mem_lsu_if #(
  parameter int BUS_W = 8
);
  logic               req;
  logic               we;
  logic [31:0]        addr;
  logic [BUS_W-1:0]   wdata;
  logic [BUS_W/8-1:0] be;
  logic               gnt;
  logic               rvalid;
  logic [BUS_W-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_lsu_pack.sv
// ---------------------------------------------------------------------------
// Module : mem_lsu_pack
// Brief  : Per-beat lane packer (store lanes, byte enables), response merge
//          into the assembly value, and final load extension.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
module mem_lsu_pack #(
  parameter int XLEN  = 32,
  parameter int BUS_W = 8
) (
  input  logic [2:0]         size,
  input  logic               sext,
  input  logic [2:0]         beat,
  input  logic [2:0]         resp_idx,
  input  logic [XLEN-1:0]    store_data,
  input  logic [XLEN-1:0]    asm_cur,
  input  logic [BUS_W-1:0]   rdata,
  output logic [BUS_W-1:0]   lane_data,
  output logic [BUS_W/8-1:0] be,
  output logic [XLEN-1:0]    asm_next,
  output logic [XLEN-1:0]    load_val
);
  localparam int BB = BUS_W / 8;
  localparam int XB = XLEN / 8;

  // Lanes below the access size are live; every multi-beat access fills the bus.
  always_comb begin
    be        = '0;
    lane_data = '0;
    asm_next  = asm_cur;
    for (int l = 0; l < BB; l++) begin
      if (l < int'(size)) begin
        be[l] = 1'b1;
        if (int'(beat) * BB + l < XB)
          lane_data[l*8 +: 8] = store_data[(int'(beat) * BB + l) * 8 +: 8];
        if (int'(resp_idx) * BB + l < XB)
          asm_next[(int'(resp_idx) * BB + l) * 8 +: 8] = rdata[l*8 +: 8];
      end
    end
  end

  // Extend the merged value so the final beat is used straight off the bus.
  always_comb begin
    load_val = asm_next;
    case (size)
      3'd1:    load_val = {{(XLEN-8){sext & asm_next[7]}}, asm_next[7:0]};
      3'd2:    load_val = {{(XLEN-16){sext & asm_next[15]}}, asm_next[15:0]};
      default: load_val = asm_next;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// Module : mem_lsu
// Brief  : MEM-stage load/store unit with pipelined beat issue, bounded
//          outstanding reads and byte enables over a 1/2/4-byte bus.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUS_W     = 8,
  parameter int MAX_OUTST = 2,
  parameter int REG_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [9:0]        opcode_i,
  input  logic              stall_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              mem_stall_request,
  mem_lsu_if.master         mc
);
  localparam int         BUS_BYTES = BUS_W / 8;
  localparam logic [2:0] BB3       = 3'(BUS_BYTES);
  localparam logic [2:0] MO3       = 3'(MAX_OUTST);

  logic [1:0]        state;
  logic [2:0]        issue_cnt, resp_cnt;
  logic [REG_AW-1:0] wd_l;
  logic              wreg_l;
  logic [XLEN-1:0]   wdata_l;
  logic [31:0]       addr_l;
  logic [2:0]        f3_l;
  logic              store_l;
  logic [XLEN-1:0]   asm_r;

  logic              is_mem;
  logic [2:0]        size, beats, outst;
  logic              sext, grant_acc, rsp_acc, last_grant, final_resp;
  logic [BUS_W-1:0]  lane_data;
  logic [BUS_BYTES-1:0] lane_be;
  logic [XLEN-1:0]   asm_next, load_val;

  assign is_mem = (opcode_i[6:0] == OP_LOAD) || (opcode_i[6:0] == OP_STORE);
  assign size   = store_l ? st_size(f3_l) : ld_size(f3_l);
  assign sext   = !store_l && ld_signed(f3_l);
  assign beats  = (size > BB3) ? size / BB3 : 3'd1;
  assign outst  = issue_cnt - resp_cnt;

  // The pin is forced low while reset is held so every output reads zero.
  assign mem_stall_request = (rst != RST_ENABLE) && is_mem && (state != ST_DONE);

  // Loads throttle on outstanding beats; stores only wait for grant.
  assign mc.req   = (state == ST_ISSUE) && (store_l || (outst < MO3));
  assign mc.we    = mc.req && store_l;
  assign mc.addr  = mc.req ? addr_l + 32'(issue_cnt) * 32'(BUS_BYTES) : '0;
  assign mc.wdata = mc.req ? lane_data : '0;
  assign mc.be    = mc.req ? lane_be : '0;

  assign grant_acc  = mc.req && mc.gnt;
  assign rsp_acc    = ((state == ST_ISSUE) || (state == ST_DRAIN)) && !store_l && mc.rvalid;
  assign last_grant = grant_acc && (issue_cnt + 3'd1 == beats);
  assign final_resp = rsp_acc && (resp_cnt + 3'd1 == beats);

  mem_lsu_pack #(.XLEN(XLEN), .BUS_W(BUS_W)) u_pack (
    .size       (size),
    .sext       (sext),
    .beat       (issue_cnt),
    .resp_idx   (resp_cnt),
    .store_data (wdata_l),
    .asm_cur    (asm_r),
    .rdata      (mc.rdata),
    .lane_data  (lane_data),
    .be         (lane_be),
    .asm_next   (asm_next),
    .load_val   (load_val)
  );

  // Access sequencing, response assembly and MEM/WB output register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      wd_l      <= '0;
      wreg_l    <= 1'b0;
      wdata_l   <= '0;
      addr_l    <= '0;
      f3_l      <= '0;
      store_l   <= 1'b0;
      asm_r     <= '0;
      wd_o      <= '0;
      wreg_o    <= 1'b0;
      wdata_o   <= '0;
    end else begin
      if (grant_acc) issue_cnt <= issue_cnt + 3'd1;
      if (rsp_acc) begin
        asm_r    <= asm_next;
        resp_cnt <= resp_cnt + 3'd1;
      end
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            wd_l      <= wd_i;
            wreg_l    <= wreg_i;
            wdata_l   <= wdata_i;
            addr_l    <= mem_addr_i;
            f3_l      <= opcode_i[9:7];
            store_l   <= (opcode_i[6:0] == OP_STORE);
            issue_cnt <= '0;
            resp_cnt  <= '0;
            asm_r     <= '0;
            state     <= ST_ISSUE;
          end else if (!stall_i) begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= wdata_i;
          end
        end
        ST_ISSUE: begin
          if (last_grant) begin
            if (store_l) begin
              wd_o    <= wd_l;
              wreg_o  <= wreg_l;
              wdata_o <= wdata_l;
              state   <= ST_DONE;
            end else if (final_resp) begin
              wd_o    <= wd_l;
              wreg_o  <= wreg_l;
              wdata_o <= load_val;
              state   <= ST_DONE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (final_resp) begin
            wd_o    <= wd_l;
            wreg_o  <= wreg_l;
            wdata_o <= load_val;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stall_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// Module : tb_mem_lsu
// Brief  : Directed bench for mem_lsu at BUS_W 8, 32 and 16 (MAX_OUTST 1),
//          with a small in-order memory controller model per instance.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
module tb_mem_lsu;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic        stall_i;
  logic [9:0]  op_a [3];

  logic [4:0]  wd_o_a    [3];
  logic        wreg_o_a  [3];
  logic [31:0] wdata_o_a [3];
  logic        msr_a     [3];
  logic        req_a     [3];
  logic        we_a      [3];
  logic [31:0] addr_a    [3];
  logic [31:0] bwd_a     [3];
  logic [3:0]  be_a      [3];
  logic        rvalid_a  [3];

  logic [7:0]  mem [0:1023];
  int          gnt_lat;
  int          rsp_lat;
  int          n_tests;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BW  = (g == 1) ? 32 : (g == 2) ? 16 : 8;
    localparam int MO  = (g == 2) ? 1 : 2;
    localparam int BBY = BW / 8;

    mem_lsu_if #(.BUS_W(BW)) bus ();
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        msr;

    mem_lsu #(.XLEN(32), .BUS_W(BW), .MAX_OUTST(MO), .REG_AW(5)) dut (
      .clk               (clk),
      .rst               (rst),
      .wd_i              (wd_i),
      .wreg_i            (wreg_i),
      .wdata_i           (wdata_i),
      .mem_addr_i        (mem_addr_i),
      .opcode_i          (op_a[g]),
      .stall_i           (stall_i),
      .wd_o              (wd_o),
      .wreg_o            (wreg_o),
      .wdata_o           (wdata_o),
      .mem_stall_request (msr),
      .mc                (bus)
    );

    // Controller model: grant after gnt_lat waiting cycles, answer reads
    // rsp_lat cycles after their grant, strictly in order.
    int          wait_cnt;
    int          cyc;
    logic [31:0] fa [8];
    int          fd [8];
    logic [3:0]  wp, rp;

    assign bus.gnt    = bus.req && (wait_cnt >= gnt_lat);
    assign bus.rvalid = (wp != rp) && (cyc >= fd[rp[2:0]]);
    always_comb begin
      bus.rdata = '0;
      for (int l = 0; l < BBY; l++)
        bus.rdata[l*8 +: 8] = mem[10'(fa[rp[2:0]] + 32'(l))];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wait_cnt <= 0;
        cyc      <= 0;
        wp       <= '0;
        rp       <= '0;
      end else begin
        cyc <= cyc + 1;
        if (bus.req && !bus.gnt) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (bus.req && bus.gnt && !bus.we) begin
          fa[wp[2:0]] <= bus.addr;
          fd[wp[2:0]] <= cyc + rsp_lat;
          wp          <= wp + 4'd1;
        end
        if (bus.rvalid) rp <= rp + 4'd1;
      end
    end

    assign wd_o_a[g]    = wd_o;
    assign wreg_o_a[g]  = wreg_o;
    assign wdata_o_a[g] = wdata_o;
    assign msr_a[g]     = msr;
    assign req_a[g]     = bus.req;
    assign we_a[g]      = bus.we;
    assign addr_a[g]    = bus.addr;
    assign bwd_a[g]     = 32'(bus.wdata);
    assign be_a[g]      = 4'(bus.be);
    assign rvalid_a[g]  = bus.rvalid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_op(input logic [2:0] f3, input logic [6:0] op);
    return {f3, op};
  endfunction

  // Step negedges until instance i drops its stall request, bounded.
  task automatic wait_done(input int i, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (msr_a[i] && n < max);
    chk($sformatf("done%0d", i), 32'(msr_a[i]), 32'd0);
  endtask

  logic [7:0] sw_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    int n;
    int first_rv, first_req2;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_addr_i = '0; stall_i = 1'b0;
    for (int i = 0; i < 3; i++) op_a[i] = '0;
    gnt_lat = 0;
    rsp_lat = 1;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    mem[10'h200] = 8'h80;
    mem[10'h003] = 8'h01; mem[10'h004] = 8'h80; mem[10'h005] = 8'h55; mem[10'h006] = 8'h66;
    mem[10'h010] = 8'hAA; mem[10'h011] = 8'hBB; mem[10'h012] = 8'hCC; mem[10'h013] = 8'hDD;
    mem[10'h020] = 8'h34; mem[10'h021] = 8'hF2;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_wdata%0d", i), wdata_o_a[i], 32'd0);
      chk($sformatf("rst_req%0d", i), 32'(req_a[i]), 32'd0);
      chk($sformatf("rst_msr%0d", i), 32'(msr_a[i]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // BUS_W=8 SW 0x11223344 at 0x100, grant every cycle
    wd_i = 5'd7; wreg_i = 1'b0; wdata_i = 32'h11223344; mem_addr_i = 32'h100;
    op_a[0] = mk_op(3'b010, OP_ST);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sw_req%0d", k), 32'(req_a[0]), 32'd1);
      chk($sformatf("sw_we%0d", k), 32'(we_a[0]), 32'd1);
      chk($sformatf("sw_addr%0d", k), addr_a[0], 32'h100 + 32'(k));
      chk($sformatf("sw_data%0d", k), bwd_a[0], 32'(sw_exp[k]));
      chk($sformatf("sw_be%0d", k), 32'(be_a[0]), 32'd1);
      chk($sformatf("sw_msr%0d", k), 32'(msr_a[0]), 32'd1);
    end
    @(negedge clk);
    chk("sw_done_msr", 32'(msr_a[0]), 32'd0);
    chk("sw_done_req", 32'(req_a[0]), 32'd0);
    chk("sw_wdata_o", wdata_o_a[0], 32'h11223344);
    chk("sw_wd_o", 32'(wd_o_a[0]), 32'd7);
    op_a[0] = '0;
    @(negedge clk);

    // BUS_W=8 LB / LBU at 0x200, 2-cycle response latency
    rsp_lat = 2;
    wd_i = 5'd3; wreg_i = 1'b1; mem_addr_i = 32'h200;
    op_a[0] = mk_op(3'b000, OP_LD);
    wait_done(0, 20, n);
    chk("lb_cycles", 32'(n), 32'd4);
    chk("lb_wdata", wdata_o_a[0], 32'hFFFFFF80);
    chk("lb_wd", 32'(wd_o_a[0]), 32'd3);
    chk("lb_wreg", 32'(wreg_o_a[0]), 32'd1);
    op_a[0] = '0;
    @(negedge clk);
    op_a[0] = mk_op(3'b100, OP_LD);
    wait_done(0, 20, n);
    chk("lbu_wdata", wdata_o_a[0], 32'h00000080);
    op_a[0] = '0;
    @(negedge clk);

    // BUS_W=32 LH at 0x3: one beat, two lanes
    rsp_lat = 1;
    mem_addr_i = 32'h3;
    op_a[1] = mk_op(3'b001, OP_LD);
    @(negedge clk);
    chk("lh32_req", 32'(req_a[1]), 32'd1);
    chk("lh32_addr", addr_a[1], 32'h3);
    chk("lh32_be", 32'(be_a[1]), 32'h3);
    wait_done(1, 20, n);
    chk("lh32_wdata", wdata_o_a[1], 32'hFFFF8001);
    op_a[1] = '0;
    @(negedge clk);

    // BUS_W=16 MAX_OUTST=1 LW at 0x10, grant latency 1, response latency 3
    gnt_lat = 1;
    rsp_lat = 3;
    mem_addr_i = 32'h10;
    op_a[2] = mk_op(3'b010, OP_LD);
    first_rv = -1;
    first_req2 = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rvalid_a[2] && first_rv < 0) first_rv = n;
      if (req_a[2] && addr_a[2] == 32'h12 && first_req2 < 0) first_req2 = n;
    end while (msr_a[2] && n < 40);
    chk("lw16_done", 32'(msr_a[2]), 32'd0);
    chk("lw16_order", 32'(first_req2 > first_rv && first_rv > 0), 32'd1);
    chk("lw16_wdata", wdata_o_a[2], 32'hDDCCBBAA);
    op_a[2] = '0;
    gnt_lat = 0;
    @(negedge clk);

    // Stall held through the final response and three further cycles
    rsp_lat = 2;
    mem_addr_i = 32'h20;
    stall_i = 1'b1;
    op_a[0] = mk_op(3'b001, OP_LD);
    wait_done(0, 20, n);
    chk("stl_wdata", wdata_o_a[0], 32'hFFFFF234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stl_hold_msr%0d", k), 32'(msr_a[0]), 32'd0);
      chk($sformatf("stl_hold_wdata%0d", k), wdata_o_a[0], 32'hFFFFF234);
    end
    stall_i = 1'b0;
    op_a[0] = mk_op(3'b000, OP_ALU);
    wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("stl_done_exit", wdata_o_a[0], 32'hFFFFF234);
    @(negedge clk);
    chk("stl_pass", wdata_o_a[0], 32'hCAFEF00D);
    stall_i = 1'b1;
    wdata_i = 32'h0BADBEEF;
    @(negedge clk);
    chk("stl_freeze", wdata_o_a[0], 32'hCAFEF00D);
    stall_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a SW
    wdata_i = 32'hA1B2C3D4;
    mem_addr_i = 32'h400;
    op_a[0] = mk_op(3'b010, OP_ST);
    repeat (3) @(negedge clk);
    chk("rs_mid_req", 32'(req_a[0]), 32'd1);
    chk("rs_mid_addr", addr_a[0], 32'h402);
    #1 rst = 1'b0;
    #1;
    chk("rs_req", 32'(req_a[0]), 32'd0);
    chk("rs_we", 32'(we_a[0]), 32'd0);
    chk("rs_addr", addr_a[0], 32'd0);
    chk("rs_bwd", bwd_a[0], 32'd0);
    chk("rs_be", 32'(be_a[0]), 32'd0);
    chk("rs_msr", 32'(msr_a[0]), 32'd0);
    chk("rs_wdata", wdata_o_a[0], 32'd0);
    chk("rs_wd", 32'(wd_o_a[0]), 32'd0);
    chk("rs_wreg", 32'(wreg_o_a[0]), 32'd0);
    op_a[0] = mk_op(3'b000, OP_ALU);
    wd_i = 5'd12; wreg_i = 1'b1; wdata_i = 32'h12345678;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rs_add_wdata", wdata_o_a[0], 32'h12345678);
    chk("rs_add_wd", 32'(wd_o_a[0]), 32'd12);
    chk("rs_add_msr", 32'(msr_a[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
